rx_core_tune_ctrl: RTL and testbench

//  Configuration sequencer for rx_core. Holds host-written shadow settings (output select, 5 NCO phase incs).

---
 rtl/rx_core_tune_ctrl_if.sv | 31 +++
 rtl/rx_core_tune_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rx_core_tune_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_core_tune_ctrl_if.sv
// Host-facing config/status bundle and rx_core-facing active settings for rx_core_tune_ctrl.
// master = register bank / host side, slave = the tune controller.
interface rx_core_tune_ctrl_if;
   logic        cfg_wr_en;
   logic [2:0]  cfg_wr_addr;
   logic [15:0] cfg_wr_data;
   logic        commit;
   logic        sweep_start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        settled;
   logic [4:0]  output_select;
   logic [15:0] compelex_phase_inc;
   logic [15:0] real_phase_inc;
   logic [15:0] duc1_phase_inc;
   logic [15:0] duc2_phase_inc;
   logic [15:0] duc3_phase_inc;

   modport master (
      output cfg_wr_en, cfg_wr_addr, cfg_wr_data, commit, sweep_start, abort,
      input  busy, done, settled, output_select, compelex_phase_inc, real_phase_inc,
             duc1_phase_inc, duc2_phase_inc, duc3_phase_inc
   );

   modport slave (
      input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, commit, sweep_start, abort,
      output busy, done, settled, output_select, compelex_phase_inc, real_phase_inc,
             duc1_phase_inc, duc2_phase_inc, duc3_phase_inc
   );
endinterface

// File: rtl/rx_core_tune_ctrl.sv
// Shadow/active configuration sequencer for rx_core: atomic apply, then settle masking.
// Define SWEEP_EN to add the compelex_phase_inc sweep mode (DWELL/STEP states, shadow addrs 6/7).
module rx_core_tune_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned DWELL_CYCLES  = 4096,
   parameter int unsigned CNT_W         = 16
) (
   input logic                clock,
   input logic                reset,
   rx_core_tune_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

`ifdef SWEEP_EN
   localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
   typedef enum logic [1:0] {StIdle, StSettle, StDwell, StStep} state_e;
`else
   typedef enum logic [0:0] {StIdle, StSettle} state_e;
`endif

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      sh_cplx_q;
   logic [15:0]      sh_real_q;
   logic [15:0]      sh_duc1_q;
   logic [15:0]      sh_duc2_q;
   logic [15:0]      sh_duc3_q;
   logic [4:0]       sh_sel_q;
   logic             start_sweep;

`ifdef SWEEP_EN
   logic [15:0] sh_step_q;
   logic [15:0] sh_stop_q;
   // Step/stop are captured at sweep start so host writes mid-sweep only affect the next sweep.
   logic [15:0] act_step_q;
   logic [15:0] act_stop_q;
   logic        sweep_q;
   logic [16:0] step_sum;
   logic        sweep_last;

   assign start_sweep = bus.sweep_start;

   always_comb begin
      step_sum   = {1'b0, bus.compelex_phase_inc} + {1'b0, act_step_q};
      sweep_last = (bus.compelex_phase_inc >= act_stop_q) || (act_step_q == 16'h0000) ||
                   step_sum[16];
   end
`else
   assign start_sweep = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q                <= StIdle;
         cnt_q                  <= '0;
         sh_cplx_q              <= '0;
         sh_real_q              <= '0;
         sh_duc1_q              <= '0;
         sh_duc2_q              <= '0;
         sh_duc3_q              <= '0;
         sh_sel_q               <= '0;
         bus.busy               <= 1'b0;
         bus.done               <= 1'b0;
         bus.settled            <= 1'b0;
         bus.output_select      <= '0;
         bus.compelex_phase_inc <= '0;
         bus.real_phase_inc     <= '0;
         bus.duc1_phase_inc     <= '0;
         bus.duc2_phase_inc     <= '0;
         bus.duc3_phase_inc     <= '0;
`ifdef SWEEP_EN
         sh_step_q              <= '0;
         sh_stop_q              <= '0;
         act_step_q             <= '0;
         act_stop_q             <= '0;
         sweep_q                <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;

         if (bus.cfg_wr_en) begin
            case (bus.cfg_wr_addr)
               3'd0:    sh_cplx_q <= bus.cfg_wr_data;
               3'd1:    sh_real_q <= bus.cfg_wr_data;
               3'd2:    sh_duc1_q <= bus.cfg_wr_data;
               3'd3:    sh_duc2_q <= bus.cfg_wr_data;
               3'd4:    sh_duc3_q <= bus.cfg_wr_data;
               3'd5:    sh_sel_q  <= bus.cfg_wr_data[4:0];
`ifdef SWEEP_EN
               3'd6:    sh_step_q <= bus.cfg_wr_data;
               3'd7:    sh_stop_q <= bus.cfg_wr_data;
`endif
               default: ;
            endcase
         end

         if (bus.abort) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.settled <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.commit || start_sweep) begin
                     bus.compelex_phase_inc <= sh_cplx_q;
                     bus.real_phase_inc     <= sh_real_q;
                     bus.duc1_phase_inc     <= sh_duc1_q;
                     bus.duc2_phase_inc     <= sh_duc2_q;
                     bus.duc3_phase_inc     <= sh_duc3_q;
                     bus.output_select      <= sh_sel_q;
                     bus.settled            <= 1'b0;
                     bus.busy               <= 1'b1;
                     cnt_q                  <= '0;
                     state_q                <= StSettle;
`ifdef SWEEP_EN
                     sweep_q                <= !bus.commit;
                     act_step_q             <= sh_step_q;
                     act_stop_q             <= sh_stop_q;
`endif
                  end
               end

               StSettle: begin
                  if (cnt_q == SettleLast) begin
                     cnt_q       <= '0;
                     bus.settled <= 1'b1;
`ifdef SWEEP_EN
                     if (sweep_q) begin
                        state_q <= StDwell;
                     end else
`endif
                     begin
                        state_q  <= StIdle;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

`ifdef SWEEP_EN
               StDwell: begin
                  if (cnt_q == DwellLast) begin
                     cnt_q       <= '0;
                     bus.settled <= 1'b0;
                     state_q     <= StStep;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               StStep: begin
                  if (sweep_last) begin
                     state_q     <= StIdle;
                     bus.busy    <= 1'b0;
                     bus.done    <= 1'b1;
                     bus.settled <= 1'b1;
                  end else begin
                     bus.compelex_phase_inc <= step_sum[15:0];
                     cnt_q                  <= '0;
                     state_q                <= StSettle;
                  end
               end
`endif

               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_core_tune_ctrl.sv
// Self-checking bench for rx_core_tune_ctrl: directed scenarios then random traffic, every cycle
// compared against a timeline model derived from commit/sweep start times.
module tb_rx_core_tune_ctrl;
   localparam int unsigned S = 64;
   localparam int unsigned D = 4;
`ifdef SWEEP_EN
   localparam bit SWEEP = 1'b1;
`else
   localparam bit SWEEP = 1'b0;
`endif

   logic clock;
   logic reset;
   int   total;
   int   bad;
   int   cyc;

   rx_core_tune_ctrl_if bus ();

   rx_core_tune_ctrl #(
      .SETTLE_CYCLES(S),
      .DWELL_CYCLES (D),
      .CNT_W        (16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   logic [15:0] sh [8];
   logic [15:0] m_cplx, m_real, m_duc1, m_duc2, m_duc3;
   logic [4:0]  m_sel;
   bit          op_on, op_sweep, m_settled;
   int          op_t0, n_pts;
   logic [15:0] sw_start, sw_step;

   function automatic int count_points(input logic [15:0] start, input logic [15:0] step,
                                       input logic [15:0] stop);
      int unsigned cur;
      int          n;
      cur = start;
      n   = 1;
      while (!(cur >= stop || step == 16'h0000 || cur + step > 32'h0000_FFFF)) begin
         cur += step;
         n++;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge(input bit we, input logic [2:0] a, input logic [15:0] d,
                             input bit cm, input bit sw, input bit ab);
      cyc++;
      if (reset) begin
         foreach (sh[i]) sh[i] = '0;
         {m_cplx, m_real, m_duc1, m_duc2, m_duc3} = '0;
         m_sel     = '0;
         op_on     = 1'b0;
         m_settled = 1'b0;
      end else begin
         if (ab) begin
            op_on     = 1'b0;
            m_settled = 1'b0;
         end else if (!op_on && (cm || (SWEEP && sw))) begin
            m_cplx    = sh[0];
            m_real    = sh[1];
            m_duc1    = sh[2];
            m_duc2    = sh[3];
            m_duc3    = sh[4];
            m_sel     = sh[5][4:0];
            op_on     = 1'b1;
            op_t0     = cyc;
            op_sweep  = !cm;
            m_settled = 1'b0;
            if (op_sweep) begin
               sw_start = sh[0];
               sw_step  = sh[6];
               n_pts    = count_points(sh[0], sh[6], sh[7]);
            end
         end
         if (we && (SWEEP || a < 3'd6)) sh[a] = d;
      end
   endtask

   task automatic check_cycle();
      logic e_busy, e_done, e_set;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_set  = m_settled;
      if (op_on) begin
         int rel;
         rel = cyc - op_t0;
         if (!op_sweep) begin
            if (rel < int'(S)) begin
               e_busy = 1'b1;
               e_set  = 1'b0;
            end else begin
               e_done    = 1'b1;
               e_set     = 1'b1;
               op_on     = 1'b0;
               m_settled = 1'b1;
            end
         end else begin
            int per, i, r;
            per = int'(S + D + 1);
            i   = rel / per;
            r   = rel % per;
            if (i < n_pts) begin
               e_busy = 1'b1;
               m_cplx = 16'(int'(sw_start) + i * int'(sw_step));
               e_set  = (r >= int'(S)) && (r < int'(S + D));
            end else begin
               e_done    = 1'b1;
               e_set     = 1'b1;
               op_on     = 1'b0;
               m_settled = 1'b1;
            end
         end
      end
      chk("busy", {15'd0, bus.busy}, {15'd0, e_busy});
      chk("done", {15'd0, bus.done}, {15'd0, e_done});
      chk("settled", {15'd0, bus.settled}, {15'd0, e_set});
      chk("output_select", {11'd0, bus.output_select}, {11'd0, m_sel});
      chk("cplx_inc", bus.compelex_phase_inc, m_cplx);
      chk("real_inc", bus.real_phase_inc, m_real);
      chk("duc1_inc", bus.duc1_phase_inc, m_duc1);
      chk("duc2_inc", bus.duc2_phase_inc, m_duc2);
      chk("duc3_inc", bus.duc3_phase_inc, m_duc3);
   endtask

   task automatic cycle(input bit we, input logic [2:0] a, input logic [15:0] d,
                        input bit cm, input bit sw, input bit ab);
      bus.cfg_wr_en   = we;
      bus.cfg_wr_addr = a;
      bus.cfg_wr_data = d;
      bus.commit      = cm;
      bus.sweep_start = sw;
      bus.abort       = ab;
      @(posedge clock);
      model_edge(we, a, d, cm, sw, ab);
      #1;
      check_cycle();
      bus.cfg_wr_en   = 1'b0;
      bus.commit      = 1'b0;
      bus.sweep_start = 1'b0;
      bus.abort       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cycle(1'b1, a, d, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      reset = 1'b1;
      bus.cfg_wr_en   = 1'b0;
      bus.cfg_wr_addr = '0;
      bus.cfg_wr_data = '0;
      bus.commit      = 1'b0;
      bus.sweep_start = 1'b0;
      bus.abort       = 1'b0;
      idle(3);
      reset = 1'b0;
      idle(2);

      // Basic commit: applies at k+1, settled/done at k+65
      wr(3'd0, 16'h1000);
      wr(3'd5, 16'h0003);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      chk("first_apply_cplx", bus.compelex_phase_inc, 16'h1000);
      idle(S - 1);
      chk("first_settle_busy", {15'd0, bus.busy}, 16'd1);
      idle(1);
      chk("first_done", {15'd0, bus.done}, 16'd1);
      idle(4);

      // Shadow write and second commit while busy
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(5);
      wr(3'd1, 16'hBEEF);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(S + 5);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(S + 5);

      // Abort in SETTLE, then a normal commit
      wr(3'd2, 16'h1234);
      wr(3'd3, 16'h5678);
      wr(3'd4, 16'h9ABC);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(10);
      cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      idle(5);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(S + 5);

      // Commit and sweep_start together: plain commit
      wr(3'd6, 16'h0100);
      wr(3'd7, 16'h0300);
      wr(3'd0, 16'h0100);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
      idle(S + 5);

      // Sweep 0x100..0x300 (ignored without SWEEP_EN)
      cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      idle(3 * (S + D + 1) + 5);

      // Overflow-terminated sweep
      wr(3'd0, 16'hFF00);
      wr(3'd6, 16'h0200);
      wr(3'd7, 16'hFFFF);
      cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      idle(2 * (S + D + 1) + 5);

      // Abort mid-sweep (in DWELL), then commit
      wr(3'd0, 16'h0010);
      wr(3'd6, 16'h0010);
      wr(3'd7, 16'h0100);
      cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      idle(int'(S + D + 1) + int'(S) + 2);
      cycle(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      idle(3);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(S + 3);

      // Reset mid-operation
      wr(3'd1, 16'h7777);
      cycle(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      idle(10);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(3);

      // Random traffic
      for (int n = 0; n < 5000; n++) begin
         cycle(($urandom % 4) == 0, 3'($urandom % 8), 16'($urandom),
               ($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 300) == 0);
      end
      idle(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
